// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - drains a show-ahead byte FIFO onto a UART 8N1 (optionally 8E1/8O1) tx line
//
// Purpose: pops one byte whenever the FIFO is non-empty and the transmitter is
// idle or finishing a stop bit, then serialises it LSB first. Back-to-back
// frames have zero idle gap.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   fifo_rdata in   8  byte at FIFO head (valid while fifo_empty=0)
//   fifo_empty in   1  FIFO empty flag
//   fifo_re    out  1  one-clk pop strobe per byte (combinational)
//   tx         out  1  serial line, idle high (registered)
//   busy       out  1  high while a frame is in progress (registered)
//
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit after the data
// bits (even when PARITY_ODD=0, odd when PARITY_ODD=1).

module uart_tx_fifo_drain #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_re,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  if (BAUD_DIV < 2 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_cfg_err
    $error("uart_tx_fifo_drain: BAUD_DIV must be >= 2 and PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             baud_last;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    baud_last = (cnt_q == CNT_LAST);

    // Gated by rst so nothing is popped (and lost) while the block is held in reset.
    fifo_re = !rst && !fifo_empty &&
              ((state_q == S_IDLE) || (state_q == S_STOP && baud_last));

    // Every baud_last either changes state or starts the next data bit, so the
    // counter simply wraps to zero there.
    if (state_q != S_IDLE && !baud_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // A pop overrides the STOP->IDLE transition for a gapless next frame.
    if (fifo_re) begin
      state_d = S_START;
      shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_rdata;
`endif
    end

    // Outputs are registered from the next state so tx changes on the same
    // edge as the state it belongs to.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d ^ (PARITY_ODD != 0);
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - self-checking bench for uart_tx_fifo_drain with a 16-deep show-ahead FIFO model

module tb_uart_tx_fifo_drain;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD       = 100;
  localparam int BAUD_DIV   = CLK_FREQ / BAUD;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CLK  = 11 * BAUD_DIV;
`else
  localparam int FRAME_CLK  = 10 * BAUD_DIV;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_re;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] sb_q[$];
  logic       pop_pending = 1'b0;

  int re_count        = 0;
  int re_run          = 0;
  int re_max_run      = 0;
  int re_while_empty  = 0;
  int busy_run        = 0;
  int last_busy_len   = 0;

  uart_tx_fifo_drain #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty),
    .fifo_re   (fifo_re),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Observers sample mid-cycle; pop request is latched here so the FIFO model
  // does not race the DUT's state update at the rising edge.
  always @(negedge clk) begin
    pop_pending = fifo_re;
    if (fifo_re && fifo_empty) re_while_empty++;
    if (fifo_re) begin
      re_count++;
      re_run++;
      if (re_run > re_max_run) re_max_run = re_run;
    end else begin
      re_run = 0;
    end
    if (busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  // Show-ahead FIFO model: head and empty flag update at the rising edge.
  always @(posedge clk) begin
    if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
    fifo_rdata <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    sb_q.push_back(b);
  endtask

  // Decode one frame, sampling each bit at its middle; compares against the
  // scoreboard head.
  task automatic rx_frame(input string tag, input int limit);
    int n;
    logic [7:0] b;
    logic [7:0] exp_b;
    n = 0;
    b = 8'h00;
    while (tx !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < limit) else begin
      errors++;
      $error("FAIL %s_start_timeout observed=%0d expected<%0d", tag, n, limit);
    end
    if (n >= limit) return;
    repeat (4) @(negedge clk);
    check({tag, "_startbit"}, tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD_DIV) @(negedge clk);
      b[i] = tx;
    end
    exp_b = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
`ifdef UART_TX_PARITY_EN
    repeat (BAUD_DIV) @(negedge clk);
    check({tag, "_parity"}, tx, (^exp_b) ^ PARITY_ODD[0]);
`endif
    repeat (BAUD_DIV) @(negedge clk);
    check({tag, "_stopbit"}, tx, 1'b1);
    check({tag, "_byte"}, b, exp_b);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_idle_reached"}, (n < limit), 1'b1);
  endtask

  initial begin
    int bad;
    int re0;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_fifo_re", fifo_re, 1'b0);
    rst = 1'b0;

    // Idle with empty FIFO
    bad = 0;
    re0 = re_count;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_fifo_re_count", re_count - re0, 0);
    check("idle_line_state", bad, 0);

    // Single byte 0x55
    re0 = re_count;
    push_byte(8'h55);
    rx_frame("single55", 50);
    wait_idle("single55", 50);
    check("single55_busy_len", last_busy_len, FRAME_CLK);
    check("single55_re_count", re_count - re0, 1);
    check("single55_re_width", re_max_run, 1);

    // Back-to-back 0xA5, 0x3C
    re0 = re_count;
    push_byte(8'hA5);
    push_byte(8'h3C);
    rx_frame("b2b_a5", 50);
    rx_frame("b2b_3c", 50);
    wait_idle("b2b", 50);
    check("b2b_busy_len", last_busy_len, 2 * FRAME_CLK);
    check("b2b_re_count", re_count - re0, 2);

    // Reset mid-frame of 0xF0
    push_byte(8'hF0);
    n = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_frame_started", (n < 50), 1'b1);
    repeat (44) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_tx", tx, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_fifo_re", fifo_re, 1'b0);
    void'(sb_q.pop_front());
    push_byte(8'h11);
    repeat (3) @(negedge clk);
    check("rstmid_no_pop_in_reset", fifo_re, 1'b0);
    rst = 1'b0;
    rx_frame("after_rst_11", 50);
    wait_idle("after_rst", 50);
    check("after_rst_fifo_drained", fifo_q.size(), 0);

    // Parity sense bytes (frame length depends on build)
    push_byte(8'h07);
    rx_frame("par07", 50);
    wait_idle("par07", 50);
    check("par07_busy_len", last_busy_len, FRAME_CLK);
    push_byte(8'h03);
    rx_frame("par03", 50);
    wait_idle("par03", 50);
    check("par03_busy_len", last_busy_len, FRAME_CLK);

    // Fill FIFO to 16, keep pushing during drain
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    for (int i = 0; i < 16; i++) begin
      rx_frame("drain_a", 50);
      if (fifo_q.size() < 16) push_byte(8'(8'h10 + i));
    end
    for (int i = 0; i < 16; i++) rx_frame("drain_b", 50);
    wait_idle("drain", 50);
    check("drain_scoreboard_empty", sb_q.size(), 0);
    check("drain_fifo_empty", fifo_q.size(), 0);
    check("never_pop_while_empty", re_while_empty, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
